// File: rtl/viterbi_pkg.sv
// Shared code definitions for the K=3, rate-1/2 convolutional encoder and the Viterbi decoder.
// Constraint length, generator polynomials, trellis state width and encoder FSM encoding.
package viterbi_pkg;

    localparam int K       = 3;
    localparam int STATE_W = K - 1;
    localparam int SYM_W   = 2;

    // Generator taps over {b, d1, d2}; MSB multiplies the newest bit.
    localparam logic [K-1:0] G0 = 3'o7;
    localparam logic [K-1:0] G1 = 3'o5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FLUSH = 2'd2
    } enc_fsm_e;

    function automatic logic gen_parity(input logic [K-1:0] taps_in, input logic [K-1:0] gen);
        return ^(taps_in & gen);
    endfunction

endpackage

// File: rtl/conv_enc_branch.sv
// One trellis branch: code symbol and successor state for input bit b leaving state {d1,d2}.
// Purely combinational so the decoder bench can use it as its trellis reference.
import viterbi_pkg::*;

module conv_enc_branch (
    input  logic               b,
    input  logic [STATE_W-1:0] state,
    output logic [SYM_W-1:0]   sym,
    output logic [STATE_W-1:0] next_state
);

    logic [K-1:0] shift_reg;

    always_comb begin
        shift_reg  = {b, state};
        sym        = {gen_parity(shift_reg, G0), gen_parity(shift_reg, G1)};
        next_state = shift_reg[K-1:1];
    end

endmodule

// File: rtl/conv_encoder.sv
// Framed rate-1/2 K=3 convolutional encoder with a one-deep registered output and two-bit zero tail.
// Optional CONV_ENC_ERRINJ_EN adds err_mask, XORed into each symbol as it is loaded.
import viterbi_pkg::*;

module conv_encoder (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
`ifdef CONV_ENC_ERRINJ_EN
    input  logic [SYM_W-1:0] err_mask,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_last
);

    enc_fsm_e           fsm_q, fsm_d;
    logic [STATE_W-1:0] enc_state_q, enc_state_d;
    logic               tail_idx_q, tail_idx_d;
    logic               out_valid_q, out_valid_d;
    logic [SYM_W-1:0]   out_sym_q, out_sym_d;
    logic               out_last_q, out_last_d;

    logic               can_load;
    logic               accept;
    logic               tail_load;
    logic               branch_b;
    logic [SYM_W-1:0]   branch_sym;
    logic [STATE_W-1:0] branch_next;
    logic [SYM_W-1:0]   inj_mask;

`ifdef CONV_ENC_ERRINJ_EN
    assign inj_mask = err_mask;
`else
    assign inj_mask = '0;
`endif

    // The output register can take a new symbol when empty or being drained this cycle.
    assign can_load  = !out_valid_q || out_ready;
    assign in_ready  = rst_n && (fsm_q != FLUSH) && can_load;
    assign accept    = in_valid && in_ready;
    assign tail_load = (fsm_q == FLUSH) && can_load;
    assign branch_b  = accept ? in_bit : 1'b0;

    conv_enc_branch u_branch (
        .b          (branch_b),
        .state      (enc_state_q),
        .sym        (branch_sym),
        .next_state (branch_next)
    );

    always_comb begin
        fsm_d       = fsm_q;
        enc_state_d = enc_state_q;
        tail_idx_d  = tail_idx_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_last_d  = out_last_q;

        if (accept || tail_load) begin
            out_valid_d = 1'b1;
            out_sym_d   = branch_sym ^ inj_mask;
            out_last_d  = tail_load && tail_idx_q;
            enc_state_d = branch_next;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (fsm_q)
            IDLE, DATA: begin
                if (accept) begin
                    fsm_d = in_last ? FLUSH : DATA;
                end
            end
            FLUSH: begin
                if (tail_load) begin
                    tail_idx_d = !tail_idx_q;
                    if (tail_idx_q) begin
                        fsm_d = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            enc_state_q <= '0;
            tail_idx_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            enc_state_q <= enc_state_d;
            tail_idx_q  <= tail_idx_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: in_valid  input  1  in_bit/in_last valid.
REQ-004 SHALL have port: in_ready  output  1  encoder accepts a data bit this cycle.
REQ-005 SHALL have port: in_bit  input  1  information bit.
REQ-006 SHALL have port: in_last  input  1  in_bit is the final data bit of the frame.
REQ-007 SHALL have port: out_valid  output  1  out_sym holds a code symbol.
REQ-008 SHALL have port: out_ready  input  1  downstream consumes out_sym this cycle.
REQ-009 SHALL have port: out_sym  output  2  code symbol; bit 1 = G0 output, bit 0 = G1 output.
REQ-010 SHALL have port: out_last  output  1  out_sym is the final tail symbol of the frame.
REQ-011 SHALL have port (only with CONV_ENC_ERRINJ_EN): err_mask  input  2  bits XORed into the symbol being loaded.

Function
REQ-012 SHALL implement rate-1/2, K=3 convolutional code, generators G0=7 (octal), G1=5 (octal).
REQ-013 SHALL hold 2-bit state {d1,d2}, d1 = previous input bit, d2 = bit before d1.
REQ-014 SHALL compute symbol for input b as G0 = b^d1^d2, G1 = b^d2; then d1<=b, d2<=d1.
REQ-015 SHALL use FSM states IDLE, DATA, FLUSH; IDLE->DATA on first accepted bit; DATA->FLUSH on accepted bit with in_last=1; FLUSH->IDLE after second tail symbol is loaded.
REQ-016 SHALL, in FLUSH, load exactly two tail symbols using b=0 without consuming input; second carries out_last=1.
REQ-017 SHALL, in IDLE/DATA, load one symbol per accepted bit; a single accepted bit with in_last=1 is a legal 1-bit frame.
REQ-018 SHALL start every frame with {d1,d2}=00; state equals 00 after two tail bits.
REQ-019 SHALL drive in_ready = (state != FLUSH) && (!out_valid || out_ready).
REQ-020 SHALL register the output: symbol appears on out_sym one cycle after the bit is accepted (latency 1).
REQ-021 SHALL hold out_sym, out_last, out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, when out_valid=1 and out_ready=1, load the next symbol the same cycle if one is available (accepted bit or tail), otherwise clear out_valid; full throughput of one symbol per cycle.
REQ-023 SHALL ignore in_bit/in_last when in_valid=0 or in_ready=0.

Reset
REQ-024 SHALL, on rst_n=0 (any time, including mid-frame or mid-flush), force FSM=IDLE, {d1,d2}=00, out_valid=0, out_sym=00, out_last=0.
REQ-025 SHALL drive in_ready=0 while rst_n=0 and resume per REQ-019 on the first edge after deassertion; partial frame is discarded, no tail emitted.

Configuration
REQ-026 SHALL, with CONV_ENC_ERRINJ_EN defined, XOR err_mask into every symbol (data or tail) at load time; encoder state is unaffected.
REQ-027 SHALL, without CONV_ENC_ERRINJ_EN, have no err_mask port and emit exact code symbols.

Structure
REQ-028 SHALL take constraint length K=3, generator constants G0/G1, state width, and the FSM state enum from shared package viterbi_pkg, also used by the decoder's branch-metric and trellis logic.
REQ-029 SHALL isolate symbol/next-state computation in one combinational sub-module conv_enc_branch (inputs b, {d1,d2}; outputs symbol, next state); the decoder bench reuses it as a trellis reference.

Verification
REQ-030 SHALL cover: bits 1,0,1,1 (last on 4th), out_ready=1 -> symbols 11,10,00,01,01,11, out_last only on the sixth, back-to-back.
REQ-031 SHALL cover: 1-bit frame in_bit=1, in_last=1 -> 11,10,11, out_last on third; in_ready=0 for the two flush cycles.
REQ-032 SHALL cover: REQ-030 stimulus with out_ready toggled 1,0,0,1 repeating -> identical symbol sequence, out_sym stable during stalls, no bit lost or duplicated.
REQ-033 SHALL cover: rst_n pulsed low after 2nd symbol of a frame -> outputs zero immediately; next frame 1,0,1,1 reproduces REQ-030 sequence exactly.
REQ-034 SHALL cover (CONV_ENC_ERRINJ_EN): REQ-030 stimulus with err_mask=10 on 3rd bit only -> 11,10,10,01,01,11.
REQ-035 SHALL cover: two frames back-to-back with in_valid held high -> second frame's first bit accepted the cycle after the final tail symbol is loaded, encoded from state 00.
